// File: rtl/instr_encoder.sv
// RV32I instruction word encoder: checks a decoded field bundle, encodes it and
// queues the resulting word in a 2-entry in-order output buffer.
module instr_encoder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op_class,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic [12:0]      imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      instr,
   output logic             err_valid,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] enc_count
);

   localparam int unsigned W_INSTR = 32;

   localparam logic [2:0] CLS_LOAD   = 3'd0;
   localparam logic [2:0] CLS_STORE  = 3'd1;
   localparam logic [2:0] CLS_RTYPE  = 3'd2;
   localparam logic [2:0] CLS_IALU   = 3'd3;
   localparam logic [2:0] CLS_BRANCH = 3'd4;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_CLASS = 2'b01;
   localparam logic [1:0] ERR_ALIGN = 2'b10;
   localparam logic [1:0] ERR_RANGE = 2'b11;

   logic [W_INSTR-1:0] word;
   logic [1:0]         chk;
   logic               accept;
   logic               push;
   logic               pop;

   logic [W_INSTR-1:0] mem [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         occ;

   // Bit placement per instruction class.
   always_comb begin
      word = '0;
      case (op_class)
         CLS_LOAD:   word = {imm[11:0], rs1, funct3, rd, 7'b0000011};
         CLS_IALU:   word = {imm[11:0], rs1, funct3, rd, 7'b0010011};
         CLS_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
         CLS_RTYPE:  word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, 7'b0110011};
         CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
         default:    word = '0;
      endcase
   end

   // Rejection reason, highest priority first.
   always_comb begin
      chk = ERR_NONE;
      if (op_class > CLS_BRANCH)
         chk = ERR_CLASS;
      else if (op_class == CLS_BRANCH && imm[0])
         chk = ERR_ALIGN;
      else if ((op_class == CLS_LOAD || op_class == CLS_STORE || op_class == CLS_IALU)
               && (imm[12] != imm[11]))
         chk = ERR_RANGE;
   end

   assign in_ready  = !rst && (occ < 2'd2);
   assign out_valid = (occ != 2'd0);
   assign instr     = out_valid ? mem[rd_ptr] : '0;

   assign accept = in_valid && in_ready;
   assign push   = accept && (chk == ERR_NONE);
   assign pop    = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0]    <= '0;
         mem[1]    <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         occ       <= 2'd0;
         err_valid <= 1'b0;
         err_code  <= ERR_NONE;
         enc_count <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= word;
            wr_ptr      <= !wr_ptr;
         end
         if (pop) begin
            rd_ptr    <= !rd_ptr;
            enc_count <= enc_count + CNT_W'(1);
         end
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
         err_valid <= accept && (chk != ERR_NONE);
         if (accept && (chk != ERR_NONE))
            err_code <= chk;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;

   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op_class;
   logic [4:0]       rd, rs1, rs2;
   logic [2:0]       funct3;
   logic             funct7b5;
   logic [12:0]      imm;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      instr;
   logic             err_valid;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] enc_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = !clk;

   instr_encoder #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_class(op_class), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
      .funct7b5(funct7b5), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
      .instr(instr), .err_valid(err_valid), .err_code(err_code), .enc_count(enc_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fields(input logic [2:0] c, input logic [4:0] d, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [2:0] f3, input logic f7,
                             input logic [12:0] im);
      op_class = c; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7b5 = f7; imm = im;
   endtask

   // Present one bundle and hold it until the edge that accepts it.
   task automatic send(input logic [2:0] c, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic f7,
                       input logic [12:0] im);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) begin
         total++;
         bad++;
         $error("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
      end
      set_fields(c, d, s1, s2, f3, f7, im);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      set_fields(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_err_valid", 32'(err_valid), 32'd0);
      chk("rst_err_code", 32'(err_code), 32'd0);
      chk("rst_enc_count", 32'(enc_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Load, one cycle latency, then pop.
      send(3'd0, 5'd5, 5'd2, 5'd0, 3'b010, 1'b0, 13'd8);
      chk("load_valid", 32'(out_valid), 32'd1);
      chk("load_instr", instr, 32'h00812283);
      pop_one();
      chk("load_count", 32'(enc_count), 32'd1);
      chk("load_empty_instr", instr, 32'd0);
      chk("load_empty_valid", 32'(out_valid), 32'd0);

      send(3'd1, 5'd0, 5'd2, 5'd5, 3'b010, 1'b0, 13'd12);
      chk("store_instr", instr, 32'h00512623);
      pop_one();

      // R-type with an imm that would fail the other checks: ignored.
      send(3'd2, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1, 13'h0801);
      chk("rtype_instr", instr, 32'h403100B3);
      chk("rtype_no_err", 32'(err_valid), 32'd0);
      pop_one();

      send(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 13'h1FFC);
      chk("branch_instr", instr, 32'hFE208EE3);
      pop_one();
      chk("count_4", 32'(enc_count), 32'd4);

      // Backpressure: two queued, third waits.
      send(3'd0, 5'd5, 5'd2, 5'd0, 3'b010, 1'b0, 13'd8);
      chk("bp_ready_after_1", 32'(in_ready), 32'd1);
      send(3'd1, 5'd0, 5'd2, 5'd5, 3'b010, 1'b0, 13'd12);
      chk("bp_ready_full", 32'(in_ready), 32'd0);
      set_fields(3'd2, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1, 13'd0);
      in_valid = 1'b1;
      step();
      step();
      chk("bp_still_full", 32'(in_ready), 32'd0);
      chk("bp_head_stable", instr, 32'h00812283);
      out_ready = 1'b1;
      step();
      chk("bp_second", instr, 32'h00512623);
      chk("bp_ready_reopen", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_third", instr, 32'h403100B3);
      chk("bp_third_valid", 32'(out_valid), 32'd1);
      step();
      out_ready = 1'b0;
      chk("bp_drained", 32'(out_valid), 32'd0);
      chk("bp_count", 32'(enc_count), 32'd7);

      // Errors.
      send(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 13'd0);
      chk("cls_err_valid", 32'(err_valid), 32'd1);
      chk("cls_err_code", 32'(err_code), 32'd1);
      chk("cls_no_word", 32'(out_valid), 32'd0);
      step();
      chk("cls_pulse_end", 32'(err_valid), 32'd0);
      chk("cls_code_hold", 32'(err_code), 32'd1);

      send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'd5);
      chk("align_err_valid", 32'(err_valid), 32'd1);
      chk("align_err_code", 32'(err_code), 32'd2);
      send(3'd3, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 13'd2048);
      chk("range_b2b_valid", 32'(err_valid), 32'd1);
      chk("range_err_code", 32'(err_code), 32'd3);
      chk("range_no_word", 32'(out_valid), 32'd0);
      send(3'd6, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'd5);
      chk("prio_err_code", 32'(err_code), 32'd1);
      step();
      chk("prio_no_word", 32'(out_valid), 32'd0);

      // Good then bad: good word stays queued.
      send(3'd3, 5'd3, 5'd4, 5'd0, 3'b000, 1'b0, 13'h1FFF);
      chk("ialu_neg_instr", instr, 32'hFFF20193);
      send(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);
      chk("gb_err", 32'(err_valid), 32'd1);
      chk("gb_head_kept", instr, 32'hFFF20193);
      pop_one();
      chk("gb_empty", 32'(out_valid), 32'd0);
      chk("gb_count", 32'(enc_count), 32'd8);

      // Asynchronous reset with a full buffer.
      send(3'd0, 5'd5, 5'd2, 5'd0, 3'b010, 1'b0, 13'd8);
      send(3'd1, 5'd0, 5'd2, 5'd5, 3'b010, 1'b0, 13'd12);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_instr", instr, 32'd0);
      chk("arst_count", 32'(enc_count), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd0);
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      step();
      chk("arst_no_ghost_valid", 32'(out_valid), 32'd0);
      chk("arst_no_ghost_count", 32'(enc_count), 32'd0);
      out_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
